// File: rtl/dmem_host_port.sv
// dmem_host_port: host-side LOAD/DUMP streaming port into DMEM; define DMEM_HOST_PORT_CHECKSUM_EN for a running checksum output
module dmem_host_port #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DMEM_SIZE = 1000
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_start_addr,
    input  logic [ADDR_W-1:0] dump_end_addr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              host_owns_mem,
    output logic              busy,
    output logic              done,
`ifdef DMEM_HOST_PORT_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              err
);
    typedef enum logic [2:0] {IDLE, LOAD, DUMP_RD, DUMP_WAIT, DUMP_OUT, FIN} state_t;

    localparam logic [ADDR_W-1:0] SIZE = ADDR_W'(DMEM_SIZE);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr, remaining, end_addr, load_clip, end_clip;

    assign busy          = state != IDLE;
    assign host_owns_mem = state != IDLE;
    assign done          = state == FIN;

    // memory bus is driven only with in-range addresses; writes happen only on a LOAD handshake
    always_comb begin
        load_clip = load_len > SIZE ? SIZE : load_len;
        end_clip  = dump_end_addr > SIZE ? SIZE : dump_end_addr;
        in_ready  = state == LOAD && remaining != '0;
        mem_we    = in_ready && in_valid;
        mem_wdata = mem_we ? in_data : '0;
        mem_addr  = in_ready || (state == DUMP_RD && addr < end_addr) ? addr : '0;
    end

    // transfer sequencer: LOAD streams words in, DUMP reads one word per pass and waits for the consumer
    always_ff @(posedge clk) begin
        if (RESET) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            end_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state     <= LOAD;
                        addr      <= '0;
                        remaining <= load_clip;
                        err       <= load_len > SIZE;
                    end else if (dump_start) begin
                        state    <= DUMP_RD;
                        addr     <= dump_start_addr;
                        end_addr <= end_clip;
                        err      <= dump_start_addr > end_clip;
                    end
                end
                LOAD: begin
                    if (mem_we) begin
                        addr      <= addr + ONE;
                        remaining <= remaining - ONE;
                    end
                    if (remaining == '0 || (mem_we && remaining == ONE)) state <= FIN;
                end
                DUMP_RD: state <= addr < end_addr ? DUMP_WAIT : FIN;
                DUMP_WAIT: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    state     <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        addr      <= addr + ONE;
                        state     <= DUMP_RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_HOST_PORT_CHECKSUM_EN
    // running sum of every word written or handed off, restarted by each accepted start
    always_ff @(posedge clk) begin
        if (RESET || (state == IDLE && (load_start || dump_start))) checksum <= '0;
        else if (mem_we) checksum <= checksum + in_data;
        else if (state == DUMP_OUT && out_ready) checksum <= checksum + out_data;
    end
`endif
endmodule

// File: tb/tb_dmem_host_port.sv
// tb_dmem_host_port: randomized and directed LOAD/DUMP bench against a queue/array reference model
module tb_dmem_host_port;
    localparam int SIZE = 1000;

    logic        clk = 1'b0, RESET = 1'b1;
    logic        load_start = 1'b0, dump_start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] load_len = '0, in_data = '0, dump_start_addr = '0, dump_end_addr = '0, mem_rdata = '0;
    logic        in_ready, out_valid, mem_we, host_owns_mem, busy, done, err;
    logic [15:0] out_data, mem_addr, mem_wdata;
`ifdef DMEM_HOST_PORT_CHECKSUM_EN
    logic [15:0] checksum;
`endif
    logic [15:0] dmem [0:1023];
    logic [15:0] ref_mem [0:SIZE-1];
    int          passed = 0, total = 0;
    logic        bad_addr = 1'b0;

    always #5 clk = ~clk;

    dmem_host_port dut (
        .clk(clk), .RESET(RESET),
        .load_start(load_start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .dump_start(dump_start), .dump_start_addr(dump_start_addr), .dump_end_addr(dump_end_addr),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .host_owns_mem(host_owns_mem), .busy(busy), .done(done),
`ifdef DMEM_HOST_PORT_CHECKSUM_EN
        .checksum(checksum),
`endif
        .err(err)
    );

    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[9:0]] <= mem_wdata;
        mem_rdata <= dmem[mem_addr[9:0]];
    end

    always @(negedge clk) if (mem_addr >= 16'(SIZE)) bad_addr <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] word(input int mode, input int i);
        return mode == 1 ? 16'((i + 1) * 10) : mode == 2 ? (i == 0 ? 16'hFFFF : 16'h0002) :
               mode == 3 ? 16'(i + 2) : 16'($urandom);
    endfunction

    task automatic do_load(input string tag, input int len, input int mode, input bit rnd);
        int          n_exp = len > SIZE ? SIZE : len;
        int          nw = 0, cyc = 0, last_w = -1, done_cyc = -1;
        bit          seq_ok = 1;
        logic [15:0] sum = '0;
        nxt();
        load_start = 1'b1;
        load_len   = 16'(len);
        nxt();
        load_start = 1'b0;
        while (done_cyc < 0 && cyc < 3000) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = word(mode, nw);
            @(negedge clk);
            if (in_ready !== (nw < n_exp)) seq_ok = 0;
            if (mem_we) begin
                if (mem_addr !== 16'(nw) || mem_wdata !== in_data || !in_valid) seq_ok = 0;
                if (nw < SIZE) ref_mem[nw] = in_data;
                sum += in_data;
                nw++;
                last_w = cyc;
            end
            if (done) done_cyc = cyc;
            cyc++;
            nxt();
        end
        in_valid = 1'b0;
        chk({tag, "_writes"}, nw, n_exp);
        chk({tag, "_seq"}, seq_ok, 1);
        chk({tag, "_done_lat"}, done_cyc - last_w, n_exp == 0 ? 2 : 1);
        chk({tag, "_err"}, err, len > SIZE);
        chk({tag, "_idle"}, busy, 0);
`ifdef DMEM_HOST_PORT_CHECKSUM_EN
        chk({tag, "_cks"}, checksum, sum);
`endif
    endtask

    task automatic do_dump(input string tag, input int s, input int e, input int stall_word, input int stall_len, input bit rnd);
        int          ee = e > SIZE ? SIZE : e;
        logic [15:0] exp_q[$], got_q[$];
        int          cyc = 0, done_cyc = -1, last_hs = -1, stalls = 0;
        bit          stable_ok = 1, held_v = 0, data_ok;
        logic [15:0] held = '0, sum = '0;
        for (int a = s; a < ee; a++) begin
            exp_q.push_back(ref_mem[a]);
            sum += ref_mem[a];
        end
        nxt();
        dump_start      = 1'b1;
        dump_start_addr = 16'(s);
        dump_end_addr   = 16'(e);
        nxt();
        dump_start = 1'b0;
        while (done_cyc < 0 && cyc < 3000) begin
            out_ready = (got_q.size() == stall_word && stalls < stall_len) ? 1'b0 :
                        rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid) begin
                if (held_v && out_data !== held) stable_ok = 0;
                held   = out_data;
                held_v = 1;
                if (out_ready) begin
                    got_q.push_back(out_data);
                    held_v  = 0;
                    last_hs = cyc;
                end else if (got_q.size() == stall_word) stalls++;
            end
            if (done) done_cyc = cyc;
            cyc++;
            nxt();
        end
        out_ready = 1'b0;
        data_ok = got_q.size() == exp_q.size();
        for (int i = 0; i < got_q.size() && data_ok; i++) if (got_q[i] !== exp_q[i]) data_ok = 0;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        chk({tag, "_data"}, data_ok, 1);
        chk({tag, "_stable"}, stable_ok, 1);
        chk({tag, "_done_lat"}, done_cyc - last_hs, 2);
        chk({tag, "_err"}, err, s > ee);
`ifdef DMEM_HOST_PORT_CHECKSUM_EN
        chk({tag, "_cks"}, checksum, sum);
`endif
    endtask

    initial begin
        int  nw;
        bit  sim_ok, late_done;
        repeat (2) nxt();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_own", host_owns_mem, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_odata", out_data, 0);
        nxt();
        RESET = 1'b0;

        do_load("load4", 4, 1, 0);
        do_load("cksum", 2, 2, 0);
        do_load("clip", 1005, 0, 0);
        do_load("pat", 8, 3, 0);
        do_dump("bp", 5, 8, 1, 5, 0);
        do_dump("empty", 10, 10, -1, 0, 0);
        do_dump("bad", 12, 3, -1, 0, 0);
        do_dump("clipend", 995, 1010, -1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            do_load("rload", int'($urandom_range(0, 20)), 0, 1);
            do_dump("rdump", int'($urandom_range(0, 25)), int'($urandom_range(0, 30)), -1, 0, 1);
        end

        nxt();
        load_start      = 1'b1;
        dump_start      = 1'b1;
        load_len        = 16'd4;
        dump_start_addr = 16'd0;
        dump_end_addr   = 16'd4;
        nxt();
        load_start = 1'b0;
        dump_start = 1'b0;
        in_valid   = 1'b1;
        nw         = 0;
        sim_ok     = 1;
        for (int c = 0; c < 3; c++) begin
            RESET   = c == 2;
            in_data = 16'($urandom);
            @(negedge clk);
            if (out_valid) sim_ok = 0;
            if (mem_we) begin
                if (mem_addr !== 16'(nw)) sim_ok = 0;
                ref_mem[nw] = in_data;
                nw++;
            end
            nxt();
        end
        RESET = 1'b0;
        chk("sim_load_wins", nw, 3);
        chk("sim_seq", sim_ok, 1);
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_we", mem_we, 0);
        chk("rst_mid_own", host_owns_mem, 0);
        chk("rst_mid_done", done, 0);
        late_done = 0;
        for (int c = 0; c < 3; c++) begin
            nxt();
            @(negedge clk);
            if (done || mem_we) late_done = 1;
        end
        in_valid = 1'b0;
        chk("rst_no_done", late_done, 0);
        do_dump("post_rst", 0, 6, -1, 0, 1);
        chk("addr_range", bad_addr, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
